fetch_queue: RTL and testbench

Four-entry instruction prefetch FIFO between the fetch stage (program counter, instruction memory, BTB lookup) and the IF/ID pipeline register. Fetch pushes each {PC+4, instruction, BTB predicted-taken} triple. Decode pops the head when it is not stalled. A flush from branch recovery or a jump discards every buffered entry in one cycle.

---
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Four-entry instruction prefetch FIFO between fetch and the IF/ID register.
// Each entry carries {predicted-taken, PC+4, instruction}; Flush empties the queue in one cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            InValid,
    input  logic [31:0]     InPCPlus4,
    input  logic [31:0]     InInstruction,
    input  logic            InPredTaken,
    output logic            InReady,
    input  logic            Flush,
    input  logic            Stall,
    output logic            OutValid,
    output logic [31:0]     OutPCPlus4,
    output logic [31:0]     OutInstruction,
    output logic            OutPredTaken,
    output logic [PTR_W:0]  Count,
    output logic            Overflow
);

    localparam int ENTRY_W = 65;
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [ENTRY_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W:0]     occupancy;
    logic               overflowQ;
    logic               doPush;
    logic               doPop;
    logic [ENTRY_W-1:0] headEntry;

    // Handshake: a push happens on a clock edge where InValid && InReady and no Flush;
    // a pop happens where OutValid && !Stall and no Flush. InReady and OutValid depend
    // only on occupancy, so a full queue refuses a push even while it pops that cycle.
    assign InReady  = (occupancy != FULL_COUNT);
    assign OutValid = (occupancy != '0);
    assign doPush   = InValid && InReady && !Flush;
    assign doPop    = OutValid && !Stall && !Flush;

    // Empty queue presents a nop with zeroed side fields rather than stale storage.
    assign headEntry      = entries[rdPtr];
    assign OutInstruction = OutValid ? headEntry[31:0]  : 32'h0000_0000;
    assign OutPCPlus4     = OutValid ? headEntry[63:32] : 32'h0000_0000;
    assign OutPredTaken   = OutValid ? headEntry[64]    : 1'b0;

    assign Count    = occupancy;
    assign Overflow = overflowQ;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
            overflowQ <= 1'b0;
        end else if (Flush) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
            overflowQ <= 1'b0;
        end else begin
            overflowQ <= InValid && !InReady;
            if (doPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({doPush, doPop})
                2'b10:   occupancy <= occupancy + COUNT_ONE;
                2'b01:   occupancy <= occupancy - COUNT_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage is never cleared; the occupancy count alone decides what is live.
    always_ff @(posedge Clk) begin
        if (doPush) begin
            entries[wrPtr] <= {InPredTaken, InPCPlus4, InInstruction};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table, hand-written corner sequences and random
// traffic, all compared against a queue-based model of the FIFO rules.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc_plus4 = '0;
  logic [31:0] in_instruction = '0;
  logic        in_pred_taken = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instruction;
  logic        out_pred_taken;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  // scoreboard: entries the model believes are buffered, {pt, pc, instr}
  logic [64:0] exp_q[$];
  logic        exp_ovf = 1'b0;

  fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .Clk(clk),
    .Rst(rst),
    .InValid(in_valid),
    .InPCPlus4(in_pc_plus4),
    .InInstruction(in_instruction),
    .InPredTaken(in_pred_taken),
    .InReady(in_ready),
    .Flush(flush),
    .Stall(stall),
    .OutValid(out_valid),
    .OutPCPlus4(out_pc_plus4),
    .OutInstruction(out_instruction),
    .OutPredTaken(out_pred_taken),
    .Count(count),
    .Overflow(overflow)
  );

  // clock block
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pt;
    logic        flush;
    logic        stall;
    logic [2:0]  e_count;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_pt;
    logic        e_ready;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic rst_n, input logic valid, input logic [31:0] pc,
                              input logic [31:0] instr, input logic pt, input logic fl,
                              input logic st, input logic [2:0] e_count, input logic e_valid,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic e_pt, input logic e_ready, input logic e_ovf);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.pc = pc; v.instr = instr; v.pt = pt;
    v.flush = fl; v.stall = st; v.e_count = e_count; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pt = e_pt; v.e_ready = e_ready; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: occupancy is the queue size; a full queue refuses pushes even when it pops.
  task automatic model_step(input logic rst_n, input logic valid, input logic [64:0] data,
                            input logic fl, input logic st);
    bit full;
    bit empty;
    if (!rst_n || fl) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      full  = (exp_q.size() == DEPTH);
      empty = (exp_q.size() == 0);
      exp_ovf = valid && full;
      if (!empty && !st) void'(exp_q.pop_front());
      if (valid && !full) exp_q.push_back(data);
    end
  endtask

  task automatic check_model(input string tag);
    logic [64:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 65'd0;
    check({tag, ".count"},   32'(count),           32'(exp_q.size()));
    check({tag, ".valid"},   32'(out_valid),       32'(exp_q.size() != 0));
    check({tag, ".ready"},   32'(in_ready),        32'(exp_q.size() != DEPTH));
    check({tag, ".instr"},   out_instruction,      head[31:0]);
    check({tag, ".pc"},      out_pc_plus4,         head[63:32]);
    check({tag, ".pt"},      32'(out_pred_taken),  32'(head[64]));
    check({tag, ".ovf"},     32'(overflow),        32'(exp_ovf));
  endtask

  // driver task: present inputs for one cycle, advance model, compare after the edge
  task automatic cycle(input logic rst_n, input logic valid, input logic [31:0] pc,
                       input logic [31:0] instr, input logic pt, input logic fl,
                       input logic st, input string tag);
    rst = rst_n; in_valid = valid; in_pc_plus4 = pc; in_instruction = instr;
    in_pred_taken = pt; flush = fl; stall = st;
    @(posedge clk);
    model_step(rst_n, valid, {pt, pc, instr}, fl, st);
    #1;
    check_model(tag);
  endtask

  initial begin
    // reset hold with fetch trying to push
    cycle(1'b0, 1'b1, 32'h4, 32'h1111_1111, 1'b1, 1'b0, 1'b0, "rst_hold0");
    cycle(1'b0, 1'b1, 32'h8, 32'h2222_2222, 1'b1, 1'b0, 1'b0, "rst_hold1");
    check("rst.count", 32'(count), 32'd0);
    check("rst.instr", out_instruction, 32'd0);
    check("rst.ready", 32'(in_ready), 32'd1);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "rst_release");

    // vector table: fill/overflow/full push+pop/drain, then flush priority
    vecs[0]  = mk(1,1,32'h04,32'h20080001,0,0,1, 3'd1,1,32'h04,32'h20080001,0,1,0);
    vecs[1]  = mk(1,1,32'h08,32'h20080002,1,0,1, 3'd2,1,32'h04,32'h20080001,0,1,0);
    vecs[2]  = mk(1,1,32'h0C,32'h20080003,0,0,1, 3'd3,1,32'h04,32'h20080001,0,1,0);
    vecs[3]  = mk(1,1,32'h10,32'h20080004,1,0,1, 3'd4,1,32'h04,32'h20080001,0,0,0);
    vecs[4]  = mk(1,1,32'h14,32'hDEADBEEF,0,0,1, 3'd4,1,32'h04,32'h20080001,0,0,1);
    vecs[5]  = mk(1,0,32'h00,32'h00000000,0,0,1, 3'd4,1,32'h04,32'h20080001,0,0,0);
    vecs[6]  = mk(1,1,32'h14,32'hDEADBEEF,0,0,0, 3'd3,1,32'h08,32'h20080002,1,1,1);
    vecs[7]  = mk(1,0,32'h00,32'h00000000,0,0,0, 3'd2,1,32'h0C,32'h20080003,0,1,0);
    vecs[8]  = mk(1,0,32'h00,32'h00000000,0,0,0, 3'd1,1,32'h10,32'h20080004,1,1,0);
    vecs[9]  = mk(1,0,32'h00,32'h00000000,0,0,0, 3'd0,0,32'h00,32'h00000000,0,1,0);
    vecs[10] = mk(1,1,32'h100,32'h11110001,0,0,1, 3'd1,1,32'h100,32'h11110001,0,1,0);
    vecs[11] = mk(1,1,32'h104,32'h11110002,1,0,1, 3'd2,1,32'h100,32'h11110001,0,1,0);
    vecs[12] = mk(1,1,32'h108,32'h11110003,0,0,1, 3'd3,1,32'h100,32'h11110001,0,1,0);
    vecs[13] = mk(1,1,32'h10C,32'h11110004,1,1,0, 3'd0,0,32'h00,32'h00000000,0,1,0);
    vecs[14] = mk(1,1,32'h110,32'h11110005,1,0,1, 3'd1,1,32'h110,32'h11110005,1,1,0);
    vecs[15] = mk(1,0,32'h00,32'h00000000,0,0,0, 3'd0,0,32'h00,32'h00000000,0,1,0);

    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].rst_n, vecs[i].valid, vecs[i].pc, vecs[i].instr, vecs[i].pt,
            vecs[i].flush, vecs[i].stall, $sformatf("vec%0d", i));
      check($sformatf("tbl%0d.count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("tbl%0d.pc", i), out_pc_plus4, vecs[i].e_pc);
      check($sformatf("tbl%0d.instr", i), out_instruction, vecs[i].e_instr);
      check($sformatf("tbl%0d.pt", i), 32'(out_pred_taken), 32'(vecs[i].e_pt));
      check($sformatf("tbl%0d.ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
      check($sformatf("tbl%0d.ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
    end

    // streaming across two pointer wraps: pop every cycle after the first push
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'(i % 3 == 0),
            1'b0, 1'b0, $sformatf("stream%0d", i));
      check($sformatf("stream%0d.count1", i), 32'(count), 32'd1);
      check($sformatf("stream%0d.head", i), out_instruction, 32'hA000_0000 + 32'(i));
    end
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "stream_drain");

    // reset asserted mid-operation together with flush and a push
    cycle(1'b1, 1'b1, 32'h300, 32'hB000_0001, 1'b1, 1'b0, 1'b1, "mid0");
    cycle(1'b1, 1'b1, 32'h304, 32'hB000_0002, 1'b0, 1'b0, 1'b1, "mid1");
    cycle(1'b0, 1'b1, 32'h308, 32'hB000_0003, 1'b0, 1'b1, 1'b0, "mid_rst");
    check("mid_rst.count", 32'(count), 32'd0);
    cycle(1'b1, 1'b1, 32'h30C, 32'hB000_0004, 1'b0, 1'b0, 1'b1, "mid_after");
    check("mid_after.head", out_instruction, 32'hB000_0004);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 99) >= 2),
            1'($urandom_range(0, 99) < 70),
            $urandom, $urandom,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) < 5),
            1'($urandom_range(0, 99) < 40),
            $sformatf("rnd%0d", i));
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
